rot_arbiter: RTL

Shares one fixed-point rotation datapath (x·cos − y·sin, x·sin + y·cos) between several vector-object requesters, such as ship, asteroids and bullets. Each requester presents a point plus its precomputed sin/cos pair on a valid/ready channel. The block arbitrates between them, pushes the winner through a 2-stage registered rotate pipeline, and returns the result tagged with the requester index. It sits between the object engines and the vector line generator.

---
 rtl/rot_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rot_arbiter.sv
// rot_arbiter: arbitrates NREQ valid/ready requesters onto one 2-stage Q1.17 rotate pipeline.
// Optional build macro ROT_ARB_FIXED_PRIO_EN selects lowest-index-wins grant with no rotating pointer.
module rot_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 18,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    input  logic [NREQ*18-1:0]     req_sin,
    input  logic [NREQ*18-1:0]     req_cos,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [DATA_W-1:0]      out_rx,
    output logic [DATA_W-1:0]      out_ry
);
    localparam int PW = DATA_W + 18;

    logic                     w_stall;
    logic                     w_found;
    logic                     w_xfer;
    logic [ID_W-1:0]          w_gnt_id;
    logic [NREQ-1:0]          w_ready;
    logic                     r_v1;
    logic [ID_W-1:0]          r_id1;
    logic signed [DATA_W-1:0] r_x1;
    logic signed [DATA_W-1:0] r_y1;
    logic signed [17:0]       r_sin1;
    logic signed [17:0]       r_cos1;
    logic signed [PW-1:0]     w_rx_t;
    logic signed [PW-1:0]     w_ry_t;
    logic [DATA_W-1:0]        w_rx_rnd;
    logic [DATA_W-1:0]        w_ry_rnd;
    logic                     r_out_valid;
    logic [ID_W-1:0]          r_out_id;
    logic [DATA_W-1:0]        r_out_rx;
    logic [DATA_W-1:0]        r_out_ry;

    assign w_stall = r_out_valid & ~out_ready;

`ifdef ROT_ARB_FIXED_PRIO_EN
    // Fixed priority: descending scan so the lowest valid index is the last one written.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(k);
            end else begin
                w_gnt_id = w_gnt_id;
            end
        end
    end
`else
    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_idx;

    // Round-robin: scan upward from r_ptr, wrapping at NREQ (which need not be a power of two).
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NREQ)) begin
                w_idx = w_idx - (ID_W+1)'(NREQ);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_W-1:0];
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Priority pointer moves just past the requester that transferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end
`endif

    assign w_xfer = w_found & ~w_stall & ~reset;

    // One-hot ready towards the winner; all zero while stalled or in reset.
    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_gnt_id] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    assign req_ready = w_ready;

    // Stage 1: capture the accepted operand set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_id1  <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_sin1 <= '0;
            r_cos1 <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_id1  <= w_gnt_id;
                r_x1   <= req_x[w_gnt_id*DATA_W +: DATA_W];
                r_y1   <= req_y[w_gnt_id*DATA_W +: DATA_W];
                r_sin1 <= req_sin[w_gnt_id*18 +: 18];
                r_cos1 <= req_cos[w_gnt_id*18 +: 18];
            end else begin
                r_id1  <= r_id1;
                r_x1   <= r_x1;
                r_y1   <= r_y1;
                r_sin1 <= r_sin1;
                r_cos1 <= r_cos1;
            end
        end else begin
            r_v1 <= r_v1;
        end
    end

    // Full-width products; the sums may wrap above the bits kept for the result.
    always_comb begin
        w_rx_t   = (PW'(r_x1) * PW'(r_cos1)) - (PW'(r_y1) * PW'(r_sin1));
        w_ry_t   = (PW'(r_x1) * PW'(r_sin1)) + (PW'(r_y1) * PW'(r_cos1));
        w_rx_rnd = w_rx_t[17 +: DATA_W] + {{(DATA_W-1){1'b0}}, w_rx_t[16]};
        w_ry_rnd = w_ry_t[17 +: DATA_W] + {{(DATA_W-1){1'b0}}, w_ry_t[16]};
    end

    // Stage 2: output registers, frozen while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_rx    <= '0;
            r_out_ry    <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_id <= r_id1;
                r_out_rx <= w_rx_rnd;
                r_out_ry <= w_ry_rnd;
            end else begin
                r_out_id <= r_out_id;
                r_out_rx <= r_out_rx;
                r_out_ry <= r_out_ry;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_rx    = r_out_rx;
    assign out_ry    = r_out_ry;

endmodule
